// File: rtl/tinyml_pkg.sv
// Shared widths and sequencer state type for the tinyml dot-product datapath.
package tinyml_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ACC_W  = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned LEN_W  = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_CAPTURE,
    S_DONE
  } seq_state_e;

endpackage

// File: rtl/mac_dot_sequencer.sv
// Streams len operand pairs from the act/wgt buffers into an external
// single-cycle MAC and captures bias + sum(act*wgt) as the result.
module mac_dot_sequencer
  import tinyml_pkg::*;
#(
  parameter int unsigned DATA_W = tinyml_pkg::DATA_W,
  parameter int unsigned ACC_W  = tinyml_pkg::ACC_W,
  parameter int unsigned ADDR_W = tinyml_pkg::ADDR_W,
  parameter int unsigned LEN_W  = tinyml_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ACC_W-1:0]  bias,
  output logic              busy,
  output logic              done,
  output logic [ACC_W-1:0]  result,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] act_rdata,
  input  logic [DATA_W-1:0] wgt_rdata,
  output logic [DATA_W-1:0] mac_a,
  output logic [DATA_W-1:0] mac_b,
  output logic [ACC_W-1:0]  mac_acc_in,
  input  logic [ACC_W-1:0]  mac_acc_out
);

  seq_state_e        r_state;
  seq_state_e        w_next;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_cnt;
  logic [ADDR_W-1:0] r_addr;
  logic [ACC_W-1:0]  r_bias;
  logic [ACC_W-1:0]  r_result;
  logic              r_dv;
  logic              r_first;
  logic              r_zero;
  logic              w_last_issue;
  logic              w_accept;

  assign w_accept     = (r_state == S_IDLE) && start;
  assign w_last_issue = (r_cnt == LEN_W'(r_len - 1'b1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A zero-length request skips the fetch pipeline but still passes through
  // CAPTURE so the done pulse lands two cycles after the accepted start.
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:    if (start) w_next = (len == '0) ? S_CAPTURE : S_FETCH;
      S_FETCH:   if (w_last_issue) w_next = S_DRAIN;
      S_DRAIN:   w_next = S_CAPTURE;
      S_CAPTURE: w_next = S_DONE;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_len    <= '0;
      r_cnt    <= '0;
      r_addr   <= '0;
      r_bias   <= '0;
      r_result <= '0;
      r_dv     <= 1'b0;
      r_first  <= 1'b0;
      r_zero   <= 1'b0;
    end else begin
      r_dv <= (r_state == S_FETCH);
      if (w_accept) begin
        r_len   <= len;
        r_addr  <= base_addr;
        r_bias  <= bias;
        r_cnt   <= '0;
        r_first <= 1'b1;
        r_zero  <= (len == '0);
      end
      if (r_state == S_FETCH) begin
        r_addr <= r_addr + 1'b1;
        r_cnt  <= r_cnt + 1'b1;
      end
      if (r_dv) begin
        r_first <= 1'b0;
      end
      if (r_state == S_CAPTURE) begin
        r_result <= r_zero ? r_bias : mac_acc_out;
      end
    end
  end

  always_comb begin
    busy       = (r_state != S_IDLE);
    done       = (r_state == S_DONE);
    rd_en      = (r_state == S_FETCH);
    rd_addr    = r_addr;
    result     = r_result;
    mac_a      = r_dv ? act_rdata : '0;
    mac_b      = r_dv ? wgt_rdata : '0;
    mac_acc_in = (r_dv && r_first) ? r_bias : mac_acc_out;
  end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
// Randomized and directed bench for mac_dot_sequencer with buffer and MAC models.
module tb_mac_dot_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [8:0]  len;
  logic [7:0]  base_addr;
  logic [15:0] bias;
  logic        busy, done, rd_en;
  logic [15:0] result;
  logic [7:0]  rd_addr;
  logic [7:0]  act_rdata = '0;
  logic [7:0]  wgt_rdata = '0;
  logic [7:0]  mac_a, mac_b;
  logic [15:0] mac_acc_in;
  logic [15:0] mac_acc_out;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int t_start  = 0;

  logic [7:0] act_mem [256];
  logic [7:0] wgt_mem [256];

  mac_dot_sequencer #(.DATA_W(8), .ACC_W(16), .ADDR_W(8), .LEN_W(9)) dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .base_addr(base_addr),
    .bias(bias), .busy(busy), .done(done), .result(result), .rd_en(rd_en),
    .rd_addr(rd_addr), .act_rdata(act_rdata), .wgt_rdata(wgt_rdata),
    .mac_a(mac_a), .mac_b(mac_b), .mac_acc_in(mac_acc_in), .mac_acc_out(mac_acc_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Buffers: synchronous read, data valid the cycle after rd_en.
  always @(posedge clk) begin
    if (rd_en) begin
      act_rdata <= act_mem[rd_addr];
      wgt_rdata <= wgt_mem[rd_addr];
    end
  end

  // mac_unit: registered acc_out = acc_in + a*b.
  always @(posedge clk or posedge reset) begin
    if (reset) mac_acc_out <= '0;
    else       mac_acc_out <= mac_acc_in + 16'(mac_a * mac_b);
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int model_dot(input int l, input int b, input int bi);
    int s = bi;
    for (int i = 0; i < l; i++)
      s += int'(act_mem[(b + i) % 256]) * int'(wgt_mem[(b + i) % 256]);
    return s & 'hFFFF;
  endfunction

  // Reference model: one run described by start cycle, length and operands.
  bit m_active = 0;
  int m_s, m_len, m_base, m_bias, m_exp;
  int m_result = 0;
  int k, lend;
  bit eb, er, ed, feed;

  always @(negedge clk) begin
    if (reset) begin
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_result", result, 0);
      chk("rst_mac_a", mac_a, 0);
      chk("rst_mac_b", mac_b, 0);
      chk("rst_acc_in", mac_acc_in, mac_acc_out);
      m_active = 0;
      m_result = 0;
    end else begin
      k    = m_active ? (cyc - m_s) : -1;
      lend = (m_len == 0) ? 2 : m_len + 3;
      eb   = m_active && k >= 1 && k <= lend;
      er   = m_active && k >= 1 && k <= m_len;
      ed   = m_active && k == lend;
      feed = m_active && m_len > 0 && k >= 2 && k <= m_len + 1;
      if (ed) m_result = m_exp;
      chk("busy", busy, int'(eb));
      chk("done", done, int'(ed));
      chk("rd_en", rd_en, int'(er));
      if (er) chk("rd_addr", rd_addr, (m_base + k - 1) % 256);
      chk("mac_a", mac_a, feed ? int'(act_mem[(m_base + k - 2) % 256]) : 0);
      chk("mac_b", mac_b, feed ? int'(wgt_mem[(m_base + k - 2) % 256]) : 0);
      chk("mac_acc_in", mac_acc_in, (feed && k == 2) ? m_bias : int'(mac_acc_out));
      chk("result", result, m_result);
      if (m_active && k >= lend) m_active = 0;
      if (start && !eb) begin
        m_active = 1;
        m_s      = cyc;
        m_len    = int'(len);
        m_base   = int'(base_addr);
        m_bias   = int'(bias);
        m_exp    = model_dot(m_len, m_base, m_bias);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start(input int l, input int b, input int bi);
    tick();
    start = 1'b1; len = 9'(l); base_addr = 8'(b); bias = 16'(bi);
    t_start = cyc;
    tick();
    start = 1'b0; len = 9'($urandom); base_addr = 8'($urandom); bias = 16'($urandom);
  endtask

  task automatic wait_done(input int max, output int lat, output int res);
    bit found = 0;
    lat = -1; res = -1;
    for (int i = 0; i < max && !found; i++) begin
      @(negedge clk);
      if (done) begin found = 1; lat = cyc - t_start; res = int'(result); end
    end
    if (!found) chk("done_timeout", 0, 1);
  endtask

  task automatic quiet(input int n, input string name);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk(name, done, 0);
    end
  endtask

  int lat, res;

  initial begin
    reset = 1'b1; start = 1'b0; len = '0; base_addr = '0; bias = '0;
    for (int i = 0; i < 256; i++) begin
      act_mem[i] = 8'($urandom);
      wgt_mem[i] = 8'($urandom);
    end
    repeat (3) tick();
    reset = 1'b0;

    act_mem[0] = 3; act_mem[1] = 2; wgt_mem[0] = 4; wgt_mem[1] = 5;
    pulse_start(2, 0, 0);
    chk("t1_model", m_exp, 22);
    wait_done(20, lat, res);
    chk("t1_latency", lat, 5);
    chk("t1_result", res, 22);
    @(negedge clk);
    chk("t1_busy_after", busy, 0);

    act_mem[40] = 3; wgt_mem[40] = 4;
    pulse_start(1, 40, 100);
    wait_done(20, lat, res);
    chk("t2_latency", lat, 4);
    chk("t2_result", res, 112);

    act_mem[0] = 255; act_mem[1] = 255; wgt_mem[0] = 255; wgt_mem[1] = 255;
    pulse_start(2, 0, 0);
    wait_done(20, lat, res);
    chk("t3_wrap_result", res, 64514);

    pulse_start(0, 77, 7);
    wait_done(20, lat, res);
    chk("t4_len0_latency", lat, 2);
    chk("t4_len0_result", res, 7);

    for (int i = 0; i < 4; i++) begin act_mem[10 + i] = 8'(i + 1); wgt_mem[10 + i] = 8'(i + 5); end
    pulse_start(4, 10, 3);
    start = 1'b1; len = 9'd7; bias = 16'd999; base_addr = 8'd50;
    tick();
    start = 1'b0;
    wait_done(20, lat, res);
    chk("t5_latency", lat, 7);
    chk("t5_result", res, 73);
    quiet(10, "t5_single_done");

    pulse_start(4, 10, 3);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_rd_en", rd_en, 0);
    tick();
    reset = 1'b0;
    quiet(8, "t6_no_done");
    act_mem[200] = 1; wgt_mem[200] = 9;
    pulse_start(1, 200, 0);
    wait_done(20, lat, res);
    chk("t6_after_rst_result", res, 9);

    // Random runs, including address wrap, long vectors and ignored mid-run starts.
    for (int r = 0; r < 40; r++) begin
      int l, b, bi;
      for (int j = 0; j < 16; j++) begin
        act_mem[$urandom_range(0, 255)] = 8'($urandom);
        wgt_mem[$urandom_range(0, 255)] = 8'($urandom);
      end
      l  = (r % 10 == 9) ? $urandom_range(250, 300) : $urandom_range(0, 24);
      b  = (r % 4 == 0) ? $urandom_range(240, 255) : $urandom_range(0, 255);
      bi = $urandom_range(0, 65535);
      pulse_start(l, b, bi);
      if (l >= 4 && $urandom_range(0, 1) == 1) begin
        start = 1'b1;
        tick();
        start = 1'b0;
      end
      wait_done(l + 20, lat, res);
      chk("rnd_latency", lat, (l == 0) ? 2 : l + 3);
      chk("rnd_result", res, model_dot(l, b, bi));
      repeat ($urandom_range(0, 3)) tick();
    end

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
